// File: rtl/dm_responder.sv
// Data-memory responder: word-addressed byte-lane store array with typed loads,
// a self-zeroing INIT sweep after reset and misaligned-access error reporting.
module dm_responder #(
   parameter int unsigned DEPTH_WORDS = 128,
   parameter int unsigned IDX_W       = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [2:0]  DMType,
   output logic [31:0] dout,
   output logic        ready,
   output logic        err_misalign,
   output logic [7:0]  err_cnt
);

   localparam logic [2:0] DT_WORD  = 3'b000;
   localparam logic [2:0] DT_HALF  = 3'b001;
   localparam logic [2:0] DT_HALFU = 3'b010;
   localparam logic [2:0] DT_BYTE  = 3'b011;
   localparam logic [2:0] DT_BYTEU = 3'b100;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   typedef enum logic {INIT, RUN} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] init_idx_q, init_idx_d;
   logic             err_misalign_q, err_misalign_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic             mem_we_c;
   logic [IDX_W-1:0] mem_idx_c;
   logic [3:0]       mem_be_c;
   logic [31:0]      mem_wdata_c;

   logic             misalign_c;
   logic [IDX_W-1:0] acc_idx_c;
   logic [31:0]      rd_word_c;
   logic [15:0]      rd_half_c;
   logic [7:0]       rd_byte_c;
   logic             unused_addr_c;

   // Address bits above the array are deliberately ignored (wrap-around).
   assign unused_addr_c = ^addr[31:IDX_W+2];
   assign acc_idx_c     = addr[IDX_W+1:2];

   // Alignment check per access type; illegal types are treated as misaligned.
   always_comb begin
      misalign_c = 1'b1;
      case (DMType)
         DT_WORD:           misalign_c = (addr[1:0] != 2'b00);
         DT_HALF, DT_HALFU: misalign_c = addr[0];
         DT_BYTE, DT_BYTEU: misalign_c = 1'b0;
         default:           misalign_c = 1'b1;
      endcase
   end

   // Next-state, memory write port and error bookkeeping.
   always_comb begin
      state_d        = state_q;
      init_idx_d     = init_idx_q;
      err_misalign_d = 1'b0;
      err_cnt_d      = err_cnt_q;
      mem_we_c       = 1'b0;
      mem_idx_c      = acc_idx_c;
      mem_be_c       = 4'b0000;
      mem_wdata_c    = din;

      if (err_misalign_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      case (state_q)
         INIT: begin
            mem_we_c    = 1'b1;
            mem_idx_c   = init_idx_q;
            mem_be_c    = 4'b1111;
            mem_wdata_c = 32'd0;
            init_idx_d  = init_idx_q + IDX_W'(1);
            if (init_idx_q == LAST_IDX) begin
               state_d = RUN;
            end
         end
         RUN: begin
            err_misalign_d = misalign_c;
            if (mem_w && !misalign_c) begin
               mem_we_c = 1'b1;
               case (DMType)
                  DT_HALF, DT_HALFU: begin
                     mem_be_c    = addr[1] ? 4'b1100 : 4'b0011;
                     mem_wdata_c = {din[15:0], din[15:0]};
                  end
                  DT_BYTE, DT_BYTEU: begin
                     mem_be_c    = 4'b0001 << addr[1:0];
                     mem_wdata_c = {4{din[7:0]}};
                  end
                  default: begin
                     mem_be_c    = 4'b1111;
                     mem_wdata_c = din;
                  end
               endcase
            end
         end
         default: state_d = INIT;
      endcase
   end

   // Control state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= INIT;
         init_idx_q     <= '0;
         err_misalign_q <= 1'b0;
         err_cnt_q      <= 8'd0;
      end else begin
         state_q        <= state_d;
         init_idx_q     <= init_idx_d;
         err_misalign_q <= err_misalign_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   // Storage array: byte-lane writes, no reset (cleared by the INIT sweep).
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         if (mem_be_c[0]) mem_q[mem_idx_c][7:0]   <= mem_wdata_c[7:0];
         if (mem_be_c[1]) mem_q[mem_idx_c][15:8]  <= mem_wdata_c[15:8];
         if (mem_be_c[2]) mem_q[mem_idx_c][23:16] <= mem_wdata_c[23:16];
         if (mem_be_c[3]) mem_q[mem_idx_c][31:24] <= mem_wdata_c[31:24];
      end
   end

   // Combinational load path; returns pre-store contents on a same-cycle store.
   always_comb begin
      rd_word_c = mem_q[acc_idx_c];
      rd_half_c = addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
      case (addr[1:0])
         2'd0:    rd_byte_c = rd_word_c[7:0];
         2'd1:    rd_byte_c = rd_word_c[15:8];
         2'd2:    rd_byte_c = rd_word_c[23:16];
         default: rd_byte_c = rd_word_c[31:24];
      endcase
      dout = 32'd0;
      if ((state_q == RUN) && !misalign_c) begin
         case (DMType)
            DT_WORD:  dout = rd_word_c;
            DT_HALF:  dout = {{16{rd_half_c[15]}}, rd_half_c};
            DT_HALFU: dout = {16'd0, rd_half_c};
            DT_BYTE:  dout = {{24{rd_byte_c[7]}}, rd_byte_c};
            DT_BYTEU: dout = {24'd0, rd_byte_c};
            default:  dout = 32'd0;
         endcase
      end
   end

   assign ready        = (state_q == RUN);
   assign err_misalign = err_misalign_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: byte-array reference model plus an
// expected-value queue popped when the load data is sampled.
module tb_dm_responder;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned IDX   = 7;
   localparam int unsigned MEMB  = DEPTH * 4;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        mem_w  = 1'b0;
   logic [31:0] addr   = 32'd0;
   logic [31:0] din    = 32'd0;
   logic [2:0]  dm_type = 3'd0;
   logic [31:0] dout;
   logic        ready;
   logic        err_misalign;
   logic [7:0]  err_cnt;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q [$];
   logic [7:0]  ref_b [MEMB];

   dm_responder #(.DEPTH_WORDS(DEPTH), .IDX_W(IDX)) dut (
      .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .din(din),
      .DMType(dm_type), .dout(dout), .ready(ready),
      .err_misalign(err_misalign), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
      $fatal(1, "watchdog");
   end

   function automatic bit model_aligned(input logic [31:0] a, input logic [2:0] t);
      case (t)
         3'd0:       return a[1:0] == 2'b00;
         3'd1, 3'd2: return a[0] == 1'b0;
         3'd3, 3'd4: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
      int unsigned i;
      logic [31:0] r;
      i = a % MEMB;
      r = 32'd0;
      if (model_aligned(a, t)) begin
         case (t)
            3'd0: r = {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]};
            3'd1: r = {{16{ref_b[i+1][7]}}, ref_b[i+1], ref_b[i]};
            3'd2: r = {16'd0, ref_b[i+1], ref_b[i]};
            3'd3: r = {{24{ref_b[i][7]}}, ref_b[i]};
            3'd4: r = {24'd0, ref_b[i]};
            default: r = 32'd0;
         endcase
      end
      return r;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      int unsigned i;
      i = a % MEMB;
      case (t)
         3'd0:       for (int k = 0; k < 4; k++) ref_b[i+k] = d[8*k +: 8];
         3'd1, 3'd2: for (int k = 0; k < 2; k++) ref_b[i+k] = d[8*k +: 8];
         3'd3, 3'd4: ref_b[i] = d[7:0];
         default: ;
      endcase
   endtask

   task automatic model_clear();
      for (int k = 0; k < int'(MEMB); k++) ref_b[k] = 8'd0;
   endtask

   task automatic idle();
      mem_w = 1'b0; addr = 32'd0; din = 32'd0; dm_type = 3'd0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp, input string nm);
      logic [31:0] got, e;
      @(negedge clk);
      mem_w = 1'b0; addr = a; dm_type = t;
      exp_q.push_back(exp);
      #2;
      got = dout;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: addr=%h type=%0d dout=%h expected=%h", nm, a, t, got, e);
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      @(negedge clk);
      mem_w = 1'b1; addr = a; din = d; dm_type = t;
      if (model_aligned(a, t)) model_store(a, d, t);
      @(negedge clk);
      idle();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         n++;
         if (ready) break;
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got=%b expected=0", ready); end
      checks++;
      if (err_misalign !== 1'b0) begin errors++; $display("FAIL reset_err: got=%b expected=0", err_misalign); end
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got=%h expected=00", err_cnt); end
      exp_q.push_back(32'd0);
      checks++;
      if (dout !== exp_q[0]) begin errors++; $display("FAIL reset_dout: got=%h expected=%h", dout, exp_q[0]); end
      void'(exp_q.pop_front());
   endtask

   task automatic test_init_sweep();
      int n;
      @(negedge clk);
      rst = 1'b1;
      wait_ready(n);
      checks++;
      if (n != 128) begin errors++; $display("FAIL init_latency: ready after %0d cycles, expected 128", n); end
      model_clear();
      do_load(32'h0000_0000, 3'd0, 32'd0, "init_zero_0");
      do_load(32'h0000_01FC, 3'd0, 32'd0, "init_zero_last");
      do_load(32'hABCD_0100, 3'd0, 32'd0, "init_zero_hi");
   endtask

   task automatic test_lanes();
      do_store(32'h10, 32'h8765_4321, 3'd0);
      do_load(32'h13, 3'd3, 32'hFFFF_FF87, "byte_signed");
      do_load(32'h13, 3'd4, 32'h0000_0087, "byte_unsigned");
      do_load(32'h12, 3'd1, 32'hFFFF_8765, "half_signed");
      do_load(32'h10, 3'd2, 32'h0000_4321, "half_unsigned");
      do_store(32'h11, 32'h0000_00AA, 3'd3);
      do_load(32'h10, 3'd0, 32'h8765_AA21, "byte_store");
      do_store(32'h12, 32'h0000_1234, 3'd1);
      do_load(32'h10, 3'd0, 32'h1234_AA21, "half_store");
   endtask

   task automatic test_misalign();
      logic [31:0] got;
      @(negedge clk);
      mem_w = 1'b1; addr = 32'h22; din = 32'h5555_5555; dm_type = 3'd0;
      exp_q.push_back(32'd0);
      #2;
      got = dout;
      checks++;
      if (got !== exp_q.pop_front()) begin errors++; $display("FAIL misalign_dout: got=%h expected=0", got); end
      @(posedge clk); #1;
      checks++;
      if (err_misalign !== 1'b1 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL misalign_pulse: err=%b cnt=%h expected err=1 cnt=00", err_misalign, err_cnt);
      end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      checks++;
      if (err_misalign !== 1'b0 || err_cnt !== 8'd1) begin
         errors++; $display("FAIL misalign_after: err=%b cnt=%h expected err=0 cnt=01", err_misalign, err_cnt);
      end
      do_load(32'h20, 3'd0, model_load(32'h20, 3'd0), "misalign_nowrite");
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         mem_w = 1'($urandom_range(0, 1));
         addr = $urandom;
         din = 32'hFFFF_FFFF;
         dm_type = 3'($urandom_range(5, 7));
      end
      @(negedge clk);
      idle();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (err_cnt !== 8'hFF) begin errors++; $display("FAIL err_saturate: cnt=%h expected=ff", err_cnt); end
      do_load(32'h11, 3'd1, 32'd0, "misalign_half_load");
      do_load(32'h10, 3'd0, 32'h1234_AA21, "illegal_type_nowrite");
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      do_store(32'h04, 32'hDEAD_BEEF, 3'd0);
      do_load(32'h04, 3'd0, 32'hDEAD_BEEF, "word_store");
      @(negedge clk);
      mem_w = 1'b1; addr = 32'h204; din = 32'h0BAD_F00D; dm_type = 3'd0;
      exp_q.push_back(model_load(32'h04, 3'd0));
      model_store(32'h204, 32'h0BAD_F00D, 3'd0);
      #2;
      got = dout;
      checks++;
      if (got !== exp_q.pop_front()) begin errors++; $display("FAIL same_cycle_load: got=%h expected=deadbeef", got); end
      @(negedge clk);
      idle();
      do_load(32'h04, 3'd0, 32'h0BAD_F00D, "wrap_store");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_w = 1'b1; addr = 32'h30 + 32'(k); din = 32'h11 * 32'(k + 1); dm_type = 3'd3;
         model_store(addr, din, 3'd3);
      end
      do_load(32'h30, 3'd0, 32'h4433_2211, "b2b_bytes");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [2:0]  t;
      for (int k = 0; k < 10; k++) begin
         a = (32'($urandom_range(0, DEPTH - 1)) * 32'd4) | ($urandom & 32'hFFFF_FE00);
         do_store(a, $urandom, 3'd0);
      end
      for (int k = 0; k < 20; k++) begin
         t = 3'($urandom_range(0, 4));
         a = $urandom;
         if (t == 3'd0) a[1:0] = 2'b00;
         else if (t != 3'd3 && t != 3'd4) a[0] = 1'b0;
         do_load(a, t, model_load(a, t), "random_load");
      end
   endtask

   task automatic test_reset_mid_init();
      int n;
      int bad;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mem_w = 1'b1; addr = 32'h10; din = 32'hFFFF_FFFF; dm_type = 3'd7;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (ready !== 1'b0 || err_misalign !== 1'b0 || dout !== 32'd0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL init_quiet: %0d bad cycles, expected 0", bad); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL mid_init_ready: got=%b expected=0", ready); end
      @(negedge clk);
      rst = 1'b1;
      dm_type = 3'd0;
      wait_ready(n);
      idle();
      checks++;
      if (n != 128) begin errors++; $display("FAIL reinit_latency: ready after %0d cycles, expected 128", n); end
      model_clear();
      do_load(32'h10, 3'd0, 32'd0, "init_ignores_store");
      do_load(32'h04, 3'd0, 32'd0, "reinit_zero_4");
      do_load(32'h1C8, 3'd0, 32'd0, "reinit_zero_hi");
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("FAIL reinit_cnt: got=%h expected=00", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_lanes();
      test_misalign();
      test_back_to_back();
      test_random();
      test_reset_mid_init();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 128, giving the number of 32-bit storage words (power of two, 16..1024).
REQ-002 The module SHALL have parameter IDX_W, default 7, equal to log2(DEPTH_WORDS).
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port mem_w  input  1  store request from the CPU MEM stage.
REQ-006 The module SHALL have port addr  input  32  byte address of the access.
REQ-007 The module SHALL have port din  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 The module SHALL have port DMType  input  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned, others illegal.
REQ-009 The module SHALL have port dout  output  32  load data, extended per DMType, combinational.
REQ-010 The module SHALL have port ready  output  1  high when initialisation is complete and accesses are honoured.
REQ-011 The module SHALL have port err_misalign  output  1  registered one-cycle pulse flagging a rejected access.
REQ-012 The module SHALL have port err_cnt  output  8  saturating count of rejected accesses.

Function
REQ-013 Word index SHALL be addr[IDX_W+1:2]; higher address bits are ignored (addresses wrap modulo DEPTH_WORDS*4).
REQ-014 FSM states SHALL be INIT and RUN; rst low forces INIT with init_idx=0.
REQ-015 In INIT, one word per cycle SHALL be written to zero at init_idx, then init_idx increments; after the write of index DEPTH_WORDS-1 the state SHALL become RUN (DEPTH_WORDS cycles total).
REQ-016 ready SHALL be 0 in INIT and 1 in RUN.
REQ-017 In INIT, mem_w SHALL be ignored and dout SHALL be 0.
REQ-018 Alignment: word requires addr[1:0]=00; half/half-unsigned require addr[0]=0; bytes are always aligned; an illegal DMType counts as misaligned.
REQ-019 A store in RUN with mem_w=1 and an aligned access SHALL update only the addressed byte lanes at the next rising edge: word all 4 lanes; half lanes {addr[1],0}..+1 from din[15:0]; byte lane addr[1:0] from din[7:0].
REQ-020 Loads in RUN SHALL be combinational from the current array contents: word as-is; half sign- or zero-extended from the lane pair selected by addr[1]; byte sign- or zero-extended from the lane selected by addr[1:0].
REQ-021 A load address matching a same-cycle store SHALL return the pre-store contents.
REQ-022 A misaligned access SHALL leave memory unchanged and force dout=0.
REQ-023 err_misalign SHALL be high for exactly the cycle after any RUN cycle that presents a misaligned access with mem_w=1, or a misaligned DMType on a non-store cycle; in INIT it SHALL stay 0.
REQ-024 err_cnt SHALL increment on each cycle in which err_misalign is asserted and SHALL saturate at 8'hFF.

Reset
REQ-025 While rst=0: ready=0, err_misalign=0, err_cnt=0, dout=0, state=INIT, init_idx=0; array contents undefined until the INIT sweep completes.
REQ-026 rst asserted mid-INIT or mid-RUN SHALL abort immediately and restart the full INIT sweep after release.
REQ-027 No storage or output SHALL depend on an uninitialised value once ready=1.

Verification
REQ-028 Release rst, DEPTH_WORDS=128 -> ready rises exactly 128 cycles later; a word load of any address then returns 0.
REQ-029 Store word 0x8765_4321 at 0x10, then load byte at 0x13 -> dout=0xFFFF_FF87; byte-unsigned -> 0x0000_0087; half at 0x12 -> 0xFFFF_8765; half-unsigned at 0x10 -> 0x0000_4321.
REQ-030 After REQ-029, store byte 0xAA at 0x11 -> word at 0x10 reads 0x8765_AA21; store half 0x1234 at 0x12 -> reads 0x1234_AA21.
REQ-031 Store word at 0x22 -> memory unchanged, err_misalign pulses one cycle, err_cnt=1; 300 further misaligned cycles -> err_cnt=0xFF.
REQ-032 Store word 0xDEAD_BEEF at 0x04 and 0x204 (wraps to index 1) -> load at 0x04 returns the last value written; same-cycle load at 0x04 during the store returns the old value.
REQ-033 Assert rst for 1 cycle during INIT at init_idx=50 -> ready stays 0 and rises 128 cycles after release; mem_w during INIT leaves all words 0.
